// File: rtl/urv_dm_arbiter.sv
// Data-memory port arbiter between uRV execute stage and a debug master.
// Optional URV_DM_ARB_ROUND_ROBIN_EN: alternate grants when both pend.
module urv_dm_arbiter #(
  parameter int unsigned g_timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        core_load_i,
  input  logic        core_store_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_data_i,
  input  logic [3:0]  core_sel_i,
  output logic        core_stall_req_o,
  output logic        core_done_o,
  output logic [31:0] core_data_o,
  output logic        core_err_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_data_i,
  input  logic [3:0]  dbg_sel_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_data_o,
  output logic        dbg_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_sel_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CORE,
    S_DBG
  } state_t;

  localparam logic [15:0] TO = 16'(g_timeout_cycles);

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic        cb_we_q, cb_we_d;
  logic [31:0] cb_addr_q, cb_addr_d;
  logic [31:0] cb_data_q, cb_data_d;
  logic [3:0]  cb_sel_q, cb_sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mreq_q, mreq_d;
  logic        mwe_q, mwe_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mdata_q, mdata_d;
  logic [3:0]  msel_q, msel_d;
  logic        cdone_q, cdone_d;
  logic [31:0] cdat_q, cdat_d;
  logic        cerr_q, cerr_d;
  logic        dack_q, dack_d;
  logic [31:0] ddat_q, ddat_d;
  logic        derr_q, derr_d;

  logic strobe, core_cand, pick_core;
  logic finish, tmo;

  assign strobe    = core_load_i | core_store_i;
  assign core_cand = pend_q | strobe;
  assign tmo       = (TO != 16'd0) && (cnt_q == TO);
  assign finish    = mem_ack_i | tmo;

`ifdef URV_DM_ARB_ROUND_ROBIN_EN
  logic last_dbg_q, last_dbg_d;

  assign pick_core = core_cand & (~dbg_req_i | last_dbg_q);

  always_comb begin
    last_dbg_d = last_dbg_q;
    if (state_q == S_IDLE && (core_cand | dbg_req_i))
      last_dbg_d = ~pick_core;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_dbg_q <= 1'b1;
    else          last_dbg_q <= last_dbg_d;
  end
`else
  assign pick_core = core_cand;
`endif

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cb_we_d   = cb_we_q;
    cb_addr_d = cb_addr_q;
    cb_data_d = cb_data_q;
    cb_sel_d  = cb_sel_q;
    cnt_d     = cnt_q;
    mreq_d    = mreq_q;
    mwe_d     = mwe_q;
    maddr_d   = maddr_q;
    mdata_d   = mdata_q;
    msel_d    = msel_q;
    cdone_d   = 1'b0;
    cdat_d    = cdat_q;
    cerr_d    = cerr_q;
    dack_d    = 1'b0;
    ddat_d    = ddat_q;
    derr_d    = derr_q;

    if (strobe && !pend_q) begin
      pend_d    = 1'b1;
      cb_we_d   = core_store_i;
      cb_addr_d = core_addr_i;
      cb_data_d = core_data_i;
      cb_sel_d  = core_sel_i;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pick_core) begin
          state_d = S_CORE;
          mreq_d  = 1'b1;
          cnt_d   = '0;
          // A fresh strobe is granted straight from the port.
          mwe_d   = pend_q ? cb_we_q   : core_store_i;
          maddr_d = pend_q ? cb_addr_q : core_addr_i;
          mdata_d = pend_q ? cb_data_q : core_data_i;
          msel_d  = pend_q ? cb_sel_q  : core_sel_i;
        end else if (dbg_req_i) begin
          state_d = S_DBG;
          mreq_d  = 1'b1;
          cnt_d   = '0;
          mwe_d   = dbg_we_i;
          maddr_d = dbg_addr_i;
          mdata_d = dbg_data_i;
          msel_d  = dbg_sel_i;
        end
      end
      S_CORE, S_DBG: begin
        if (finish) begin
          state_d = S_IDLE;
          mreq_d  = 1'b0;
          if (state_q == S_CORE) begin
            pend_d  = 1'b0;
            cdone_d = 1'b1;
            cdat_d  = mem_ack_i ? mem_data_i : '0;
            cerr_d  = ~mem_ack_i;
          end else begin
            dack_d = 1'b1;
            ddat_d = mem_ack_i ? mem_data_i : '0;
            derr_d = ~mem_ack_i;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      cb_we_q   <= 1'b0;
      cb_addr_q <= '0;
      cb_data_q <= '0;
      cb_sel_q  <= '0;
      cnt_q     <= '0;
      mreq_q    <= 1'b0;
      mwe_q     <= 1'b0;
      maddr_q   <= '0;
      mdata_q   <= '0;
      msel_q    <= '0;
      cdone_q   <= 1'b0;
      cdat_q    <= '0;
      cerr_q    <= 1'b0;
      dack_q    <= 1'b0;
      ddat_q    <= '0;
      derr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      cb_we_q   <= cb_we_d;
      cb_addr_q <= cb_addr_d;
      cb_data_q <= cb_data_d;
      cb_sel_q  <= cb_sel_d;
      cnt_q     <= cnt_d;
      mreq_q    <= mreq_d;
      mwe_q     <= mwe_d;
      maddr_q   <= maddr_d;
      mdata_q   <= mdata_d;
      msel_q    <= msel_d;
      cdone_q   <= cdone_d;
      cdat_q    <= cdat_d;
      cerr_q    <= cerr_d;
      dack_q    <= dack_d;
      ddat_q    <= ddat_d;
      derr_q    <= derr_d;
    end
  end

  assign core_stall_req_o = pend_q;
  assign core_done_o      = cdone_q;
  assign core_data_o      = cdat_q;
  assign core_err_o       = cerr_q;
  assign dbg_ack_o        = dack_q;
  assign dbg_data_o       = ddat_q;
  assign dbg_err_o        = derr_q;
  assign mem_req_o        = mreq_q;
  assign mem_we_o         = mwe_q;
  assign mem_addr_o       = maddr_q;
  assign mem_data_o       = mdata_q;
  assign mem_sel_o        = msel_q;

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Scoreboard bench for urv_dm_arbiter: random core/debug traffic
// against a behavioural memory with random ack latency.
module tb_urv_dm_arbiter;

  localparam int TO = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } req_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        core_load_i = 0, core_store_i = 0;
  logic [31:0] core_addr_i = 0, core_data_i = 0;
  logic [3:0]  core_sel_i = 0;
  logic        core_stall_req_o, core_done_o, core_err_o;
  logic [31:0] core_data_o;
  logic        dbg_req_i = 0, dbg_we_i = 0;
  logic [31:0] dbg_addr_i = 0, dbg_data_i = 0;
  logic [3:0]  dbg_sel_i = 0;
  logic        dbg_ack_o, dbg_err_o;
  logic [31:0] dbg_data_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [3:0]  mem_sel_o;
  logic        mem_ack_i = 0;
  logic [31:0] mem_data_i = 0;

  int tests = 0;
  int fails = 0;
  int force_w = -1;
  bit spur_en = 0;

  req_t        core_q[$];
  req_t        dbg_q[$];
  logic [31:0] glog[$];

  req_t cur;
  int   cur_w;
  int   cyc;
  bit   busy = 0;

  urv_dm_arbiter #(.g_timeout_cycles(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .core_load_i(core_load_i), .core_store_i(core_store_i),
    .core_addr_i(core_addr_i), .core_data_i(core_data_i),
    .core_sel_i(core_sel_i), .core_stall_req_o(core_stall_req_o),
    .core_done_o(core_done_o), .core_data_o(core_data_o),
    .core_err_o(core_err_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
    .dbg_addr_i(dbg_addr_i), .dbg_data_i(dbg_data_i),
    .dbg_sel_i(dbg_sel_i), .dbg_ack_o(dbg_ack_o),
    .dbg_data_o(dbg_data_o), .dbg_err_o(dbg_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_sel_o(mem_sel_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory: random wait w before ack; timeout expected when w > TO.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0;
      mem_ack_i = 0;
    end else if (mem_req_o) begin
      if (!busy) begin
        busy = 1;
        cur.we = mem_we_o;
        cur.addr = mem_addr_o;
        cur.data = mem_data_o;
        cur.sel = mem_sel_o;
        cyc = 0;
        glog.push_back(mem_addr_o);
        if (force_w >= 0) cur_w = force_w;
        else if ($urandom_range(0, 9) == 0) cur_w = 5 + $urandom_range(0, 2);
        else cur_w = $urandom_range(0, 4);
      end else begin
        chk("mem_stable", {mem_we_o, mem_sel_o, mem_addr_o[26:0]},
            {cur.we, cur.sel, cur.addr[26:0]});
        chk("mem_stable_d", mem_data_o, cur.data);
      end
      cyc++;
      mem_ack_i = (cyc == cur_w + 1);
      mem_data_i = mem_ack_i ? mdat(cur.addr) : $urandom;
    end else begin
      if (busy) begin
        busy = 0;
        chk("req_len", cyc, (cur_w > TO) ? TO + 1 : cur_w + 1);
      end
      mem_ack_i = spur_en && ($urandom_range(0, 3) == 0);
      mem_data_i = $urandom;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    req_t e;
    bit   eerr;
    if (rst_n) begin
      chk("stall", core_stall_req_o,
          (core_q.size() != 0) && !core_done_o);
      if (core_done_o) begin
        if (core_q.size() == 0) begin
          chk("core_done_unexp", core_done_o, 0);
        end else begin
          e = core_q.pop_front();
          eerr = cur_w > TO;
          chk("core_we", cur.we, e.we);
          chk("core_addr", cur.addr, e.addr);
          chk("core_sel", cur.sel, e.sel);
          if (e.we) chk("core_wdata", cur.data, e.data);
          chk("core_err", core_err_o, eerr);
          chk("core_data", core_data_o, eerr ? 0 : mdat(e.addr));
        end
      end
      if (dbg_ack_o) begin
        if (dbg_q.size() == 0) begin
          chk("dbg_ack_unexp", dbg_ack_o, 0);
        end else begin
          e = dbg_q.pop_front();
          eerr = cur_w > TO;
          chk("dbg_we", cur.we, e.we);
          chk("dbg_addr", cur.addr, e.addr);
          chk("dbg_sel", cur.sel, e.sel);
          if (e.we) chk("dbg_wdata", cur.data, e.data);
          chk("dbg_err", dbg_err_o, eerr);
          chk("dbg_data", dbg_data_o, eerr ? 0 : mdat(e.addr));
        end
      end
    end
  end

  task automatic core_go(input bit ld, input bit st, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_t r;
    core_load_i = ld;
    core_store_i = st;
    core_addr_i = a;
    core_data_i = d;
    core_sel_i = s;
    r.we = st;
    r.addr = a;
    r.data = d;
    r.sel = s;
    core_q.push_back(r);
  endtask

  task automatic dbg_go(input bit we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    req_t r;
    dbg_req_i = 1;
    dbg_we_i = we;
    dbg_addr_i = a;
    dbg_data_i = d;
    dbg_sel_i = s;
    r.we = we;
    r.addr = a;
    r.data = d;
    r.sel = s;
    dbg_q.push_back(r);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_outs"}, {core_stall_req_o, core_done_o, core_err_o,
        dbg_ack_o, dbg_err_o, mem_req_o, mem_we_o, mem_sel_o}, 0);
    chk({nm, "_cdata"}, core_data_o, 0);
    chk({nm, "_ddata"}, dbg_data_o, 0);
    chk({nm, "_maddr"}, mem_addr_o, 0);
    chk({nm, "_mdata"}, mem_data_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    check_zero("reset");
    #1 rst_n = 1;

    // Simultaneous core store and debug read right after reset.
    force_w = 3;
    glog.delete();
    @(negedge clk); #1;
    core_go(0, 1, 32'h204, 32'h1234_5678, 4'b0011);
    dbg_go(0, 32'h300, 32'h0, 4'hF);
    @(negedge clk); #1;
    core_load_i = 0;
    core_store_i = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); #1;
      if (dbg_q.size() == 0) dbg_req_i = 0;
      ok = (dbg_q.size() == 0) && (core_q.size() == 0);
    end
    chk("both_done", ok, 1);
    chk("grant_cnt", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("grant0_core", glog[0], 32'h204);
      chk("grant1_dbg", glog[1], 32'h300);
    end

    // Minimum-latency core load with a spurious ack beforehand.
    spur_en = 1;
    repeat (4) @(negedge clk);
    spur_en = 0;
    force_w = 0;
    @(negedge clk); #1;
    core_go(1, 0, 32'h100, 32'h0, 4'hF);
    @(negedge clk);
    chk("lat_stall1", core_stall_req_o, 1);
    chk("lat_req1", mem_req_o, 1);
    chk("lat_done1", core_done_o, 0);
    #1 core_load_i = 0;
    @(negedge clk);
    chk("lat_done2", core_done_o, 1);
    chk("lat_req2", mem_req_o, 0);
    chk("lat_data2", core_data_o, mdat(32'h100));
    #1;

    // Random traffic.
    force_w = -1;
    spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      core_load_i = 0;
      core_store_i = 0;
      if ($urandom_range(0, 3) == 0) begin
        int r = $urandom_range(0, 2);
        if (core_q.size() == 0) begin
          core_go(r != 1, r != 0, $urandom, $urandom, 4'($urandom));
        end else begin
          core_load_i = (r != 1);
          core_store_i = (r != 0);
          core_addr_i = $urandom;
          core_data_i = $urandom;
          core_sel_i = 4'($urandom);
        end
      end
      if (dbg_q.size() == 0) begin
        if ($urandom_range(0, 2) == 0)
          dbg_go(1'($urandom), $urandom, $urandom, 4'($urandom));
        else
          dbg_req_i = 0;
      end
    end
    @(negedge clk); #1;
    core_load_i = 0;
    core_store_i = 0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (dbg_q.size() == 0) dbg_req_i = 0;
      ok = (dbg_q.size() == 0) && (core_q.size() == 0) && !mem_req_o;
    end
    chk("drain", ok, 1);

    // Reset in the middle of a core access.
    force_w = 20;
    @(negedge clk); #1;
    core_go(1, 0, 32'h400, 32'h0, 4'hF);
    @(negedge clk); #1;
    core_load_i = 0;
    #1 rst_n = 0;
    #1 check_zero("midrst");
    core_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_done", core_done_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
